// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared widths, function codes and sequencer state type
//
// Purpose: common definitions for the vector ALU sequencer, its ALU-side
// interface and the bench. Widths match the downstream ALU.
package vec_pkg;

  localparam int DATA_W  = 21;  // element width
  localparam int LANES   = 8;   // maximum elements per vector
  localparam int IDX_W   = 3;   // element index width
  localparam int FUNCT_W = 3;   // ALU function code width

  localparam logic [FUNCT_W-1:0] FN_MOV = 3'b000;
  localparam logic [FUNCT_W-1:0] FN_ADD = 3'b010;
  localparam logic [FUNCT_W-1:0] FN_SUB = 3'b011;
  localparam logic [FUNCT_W-1:0] FN_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Only the four codes the ALU implements are accepted.
  function automatic logic is_legal_funct(input logic [FUNCT_W-1:0] f);
    return (f == FN_MOV) || (f == FN_ADD) || (f == FN_SUB) || (f == FN_MUL);
  endfunction

endpackage

// File: rtl/vec_alu_sequencer_if.sv
// rtl/vec_alu_sequencer_if.sv - element-level link between sequencer and ALU
//
// Purpose: bundles the per-element ALU operands, function code, enable and
// the combinational result.
//   master (sequencer): drives alu_op1, alu_op2, alu_funct, alu_flag;
//                       reads alu_result
//   slave  (ALU):       reads operands/funct/flag; drives alu_result
interface vec_alu_sequencer_if;
  import vec_pkg::*;

  logic [DATA_W-1:0]  alu_op1;
  logic [DATA_W-1:0]  alu_op2;
  logic [FUNCT_W-1:0] alu_funct;
  logic               alu_flag;
  logic [DATA_W-1:0]  alu_result;

  modport master (
    output alu_op1,
    output alu_op2,
    output alu_funct,
    output alu_flag,
    input  alu_result
  );

  modport slave (
    input  alu_op1,
    input  alu_op2,
    input  alu_funct,
    input  alu_flag,
    output alu_result
  );

endinterface

// File: rtl/vec_alu_sequencer.sv
// rtl/vec_alu_sequencer.sv - streams a captured vector op through the ALU one element per cycle
//
// Purpose: accepts a whole vector operation in one cycle, feeds one element
// pair per cycle to the combinational ALU and collects the results.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin an op; ignored while busy
//   funct, vlen        ALU function code, element count (clamped to LANES)
//   op1_vec, op2_vec   operand vectors, element i at [i*DATA_W +: DATA_W]
//   alu                ALU link (master side)
//   res_vec            result vector, same packing
//   busy, done, err    in-progress, one-cycle completion pulse, sticky illegal funct
module vec_alu_sequencer
  import vec_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [FUNCT_W-1:0]      funct,
  input  logic [IDX_W:0]          vlen,
  input  logic [LANES*DATA_W-1:0] op1_vec,
  input  logic [LANES*DATA_W-1:0] op2_vec,
  vec_alu_sequencer_if.master     alu,
  output logic [LANES*DATA_W-1:0] res_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam logic [IDX_W:0] LANES_V = (IDX_W+1)'(LANES);

  seq_state_t                     state;
  logic [IDX_W-1:0]               idx;
  logic [FUNCT_W-1:0]             funct_q;
  logic [IDX_W:0]                 vlen_q;
  logic [LANES-1:0][DATA_W-1:0]   op1_q;
  logic [LANES-1:0][DATA_W-1:0]   op2_q;
  logic [LANES-1:0][DATA_W-1:0]   res_q;
  logic [IDX_W:0]                 last_idx;
  logic                           run;

  assign run      = (state == RUN);
  assign last_idx = vlen_q - (IDX_W+1)'(1);

  // Operands are driven only in RUN so the ALU sees quiet inputs otherwise.
  assign alu.alu_flag  = run;
  assign alu.alu_op1   = run ? op1_q[idx] : '0;
  assign alu.alu_op2   = run ? op2_q[idx] : '0;
  assign alu.alu_funct = run ? funct_q    : '0;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign res_vec = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      funct_q <= '0;
      vlen_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op1_q   <= op1_vec;
            op2_q   <= op2_vec;
            funct_q <= funct;
            vlen_q  <= (vlen > LANES_V) ? LANES_V : vlen;
            idx     <= '0;
            err     <= 1'b0;
            // Illegal code or empty vector finish immediately with no writes.
            if (!is_legal_funct(funct)) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (vlen == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          res_q[idx] <= alu.alu_result;
          idx        <= idx + IDX_W'(1);
          if ({1'b0, idx} == last_idx) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
